// File: rtl/arya_pkt_tx_pkg.sv
// Shared types and constants for the Arya packet transmitter.
// Holds the IOQ ctrl codes, the FSM encoding and the FIFO word layout.
package arya_pkt_tx_pkg;

  localparam int DATA_MEM_ADDR_WIDTH = 9;
  localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;
  localparam logic [7:0] EOP_ALL_VALID      = 8'h01;
  localparam logic [7:0] CTRL_PAYLOAD       = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DRAIN   = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } tx_word_t;

  // IOQ module header: {dst_port, word_len, src_port, byte_len}
  function automatic logic [63:0] ioq_header(input logic [15:0] dst, input logic [15:0] words);
    return {dst, words, 16'h0000, words << 3};
  endfunction

endpackage

// File: rtl/arya_tx_fifo.sv
// Two-entry {ctrl,data} FIFO; push and pop may coincide, including when full.
module arya_tx_fifo
  import arya_pkt_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  tx_word_t   push_word,
  input  logic       pop,
  output tx_word_t   head,
  output logic       not_empty,
  output logic [1:0] count
);

  tx_word_t mem [2];
  logic     wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count != 2'd0);

endmodule

// File: rtl/arya_pkt_tx.sv
// Packet transmitter: reads a block of data-memory words and sends it as
// an IOQ-headed packet on the user datapath output.
module arya_pkt_tx
  import arya_pkt_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH = DATA_MEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] start_base,
  input  logic [MEM_ADDR_WIDTH:0]   start_len,
  input  logic [15:0]               start_dst_port,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               pkt_count,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic                      out_wr,
  input  logic                      out_rdy
);

  localparam logic [MEM_ADDR_WIDTH:0] LEN_ONE = (MEM_ADDR_WIDTH+1)'(1);

  tx_state_e                 state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_ADDR_WIDTH:0]   rem_q;
  logic                      rd_vld_q, rd_last_q;
  logic                      accept, issue, pop, push;
  logic                      fifo_ne;
  logic [1:0]                fifo_cnt;
  logic [2:0]                credit_use;
  tx_word_t                  push_word, head;

  assign accept = (state_q == IDLE) && start && (start_len != '0);

  // At most two words may be buffered or in flight; a word leaving this cycle frees a slot.
  assign credit_use = {1'b0, fifo_cnt} + {2'b00, rd_vld_q};
  assign issue      = (state_q == PAYLOAD) && (credit_use < 3'd2 + {2'b00, pop});

  assign pop    = fifo_ne && out_rdy;
  assign out_wr = pop;
  assign push   = accept || rd_vld_q;

  always_comb begin
    push_word = '0;
    if (rd_vld_q) begin
      push_word.ctrl = rd_last_q ? EOP_ALL_VALID : CTRL_PAYLOAD;
      push_word.data = mem_rd_data;
    end else begin
      push_word.ctrl = IO_QUEUE_STAGE_NUM;
      push_word.data = ioq_header(start_dst_port, 16'(start_len));
    end
  end

  arya_tx_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .not_empty (fifo_ne),
    .count     (fifo_cnt)
  );

  assign out_data    = head.data;
  assign out_ctrl    = head.ctrl;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = PAYLOAD;
      PAYLOAD: if (issue && rem_q == LEN_ONE) state_d = DRAIN;
      DRAIN: begin
        if (!fifo_ne && !rd_vld_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      pkt_count <= 32'd0;
    end else begin
      state_q   <= state_d;
      rd_vld_q  <= issue;
      rd_last_q <= issue && (rem_q == LEN_ONE);
      if (accept) begin
        addr_q <= start_base;
        rem_q  <= start_len;
      end else if (issue) begin
        addr_q <= addr_q + MEM_ADDR_WIDTH'(1);
        rem_q  <= rem_q - LEN_ONE;
      end
      if (done) pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_arya_pkt_tx.sv
// Bench for arya_pkt_tx: directed vector table, hand-written corner sequences
// and randomized packets, checked against a queue-based packet model.
module tb_arya_pkt_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  start_base = '0;
  logic [9:0]  start_len = '0;
  logic [15:0] start_dst_port = '0;
  logic        busy, done, mem_rd_en, out_wr;
  logic        out_rdy = 1'b0;
  logic [31:0] pkt_count;
  logic [8:0]  mem_rd_addr;
  logic [63:0] mem_rd_data = '0;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;

  always #5 clk = ~clk;

  arya_pkt_tx dut (
    .clk(clk), .reset(reset), .start(start), .start_base(start_base),
    .start_len(start_len), .start_dst_port(start_dst_port), .busy(busy),
    .done(done), .pkt_count(pkt_count), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .out_data(out_data),
    .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy)
  );

  // data memory with one-cycle read latency
  logic [63:0] mem [512];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    logic [8:0]  base;
    logic [9:0]  len;
    logic [15:0] dst;
    int          mode;   // 0: rdy high, 1: rdy 1-of-3, 2: random rdy
    logic [63:0] hdr;
    int          xs_rel; // cycle of an extra start pulse that must be ignored, -1 none
  } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0;
  int xfer_idx, hdr_pend, reads, pay_out, cur_len, done_cnt = 0, exp_pkts = 0;
  bit tmode, active, done_seen;
  logic [71:0] exp_q [$];
  logic [8:0]  addr_q [$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_hdr(input logic [15:0] d, input int l);
    return {d, 16'(l), 16'h0000, 16'(l * 8)};
  endfunction

  function automatic logic pick_rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic sample();
    int rel;
    rel = cyc - start_cyc;
    if (out_wr) begin
      chk("wr_with_rdy", 72'(out_rdy), 72'(1));
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %h/%h expected none", out_ctrl, out_data);
      end else begin
        chk("word", {out_ctrl, out_data}, exp_q.pop_front());
        if (tmode) chk("word_cycle", 72'(rel), 72'((xfer_idx == 0) ? 1 : xfer_idx + 2));
      end
      if (xfer_idx == 0) hdr_pend = 0; else pay_out++;
      xfer_idx++;
    end
    if (mem_rd_en) begin
      reads++;
      if (addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got %h expected none", mem_rd_addr);
      end else chk("rd_addr", 72'(mem_rd_addr), 72'(addr_q.pop_front()));
    end
    if (active) chk("outstanding_le2", 72'((hdr_pend + reads - pay_out) <= 2), 72'(1));
    if (done) begin
      done_cnt++;
      done_seen = 1'b1;
      if (tmode) chk("done_cycle", 72'(rel), 72'(cur_len + 3));
    end
  endtask

  task automatic step(input logic rdy, input logic st, input logic [8:0] b,
                      input logic [9:0] l, input logic [15:0] d);
    @(posedge clk); #1;
    cyc++;
    out_rdy = rdy; start = st; start_base = b; start_len = l; start_dst_port = d;
    @(negedge clk);
    sample();
  endtask

  task automatic setup(input logic [8:0] b, input int l, input logic [63:0] hdr, input bit tm);
    exp_q.delete(); addr_q.delete();
    exp_q.push_back({8'hFF, hdr});
    for (int i = 0; i < l; i++) begin
      exp_q.push_back({(i == l - 1) ? 8'h01 : 8'h00, mem[(int'(b) + i) % 512]});
      addr_q.push_back(9'((int'(b) + i) % 512));
    end
    xfer_idx = 0; hdr_pend = 1; reads = 0; pay_out = 0;
    cur_len = l; tmode = tm; active = 1'b1; done_seen = 1'b0;
    start_cyc = cyc + 1;
  endtask

  task automatic run_pkt(input logic [8:0] b, input int l, input logic [15:0] d,
                         input int mode, input logic [63:0] hdr, input int xs_rel);
    setup(b, l, hdr, mode == 0);
    step(pick_rdy(mode, 0), 1'b1, b, 10'(l), d);
    for (int k = 1; k < 4 * l + 60 && !done_seen; k++)
      step(pick_rdy(mode, k), k == xs_rel, 9'h000, 10'd3, 16'hDEAD);
    if (!done_seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done for len %0d", l);
    end
    exp_pkts++;
    repeat (8) step(1'b1, 1'b0, 9'h000, 10'd0, 16'h0000);
    active = 1'b0;
    chk("pkt_words_left", 72'(exp_q.size()), 72'(0));
    chk("pkt_reads_left", 72'(addr_q.size()), 72'(0));
    chk("pkt_xfers", 72'(xfer_idx), 72'(l + 1));
    chk("done_count", 72'(done_cnt), 72'(exp_pkts));
    chk("pkt_count", 72'(pkt_count), 72'(exp_pkts));
    chk("busy_idle", 72'(busy), 72'(0));
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{9'h010, 10'd4,   16'h0004, 0, 64'h0004_0004_0000_0020, -1};
    vecs[1] = '{9'h055, 10'd1,   16'h0ABC, 0, 64'h0ABC_0001_0000_0008, -1};
    vecs[2] = '{9'h1FE, 10'd4,   16'h1234, 0, 64'h1234_0004_0000_0020, -1};
    vecs[3] = '{9'h100, 10'd8,   16'h0002, 1, 64'h0002_0008_0000_0040, -1};
    vecs[4] = '{9'h020, 10'd2,   16'h00AA, 0, 64'h00AA_0002_0000_0010, 5};
    vecs[5] = '{9'h030, 10'd5,   16'h00BB, 0, 64'h00BB_0005_0000_0028, 3};
    vecs[6] = '{9'h1C0, 10'd512, 16'hFFFF, 0, 64'hFFFF_0200_0000_1000, -1};
    vecs[7] = '{9'h1FF, 10'd3,   16'h0001, 2, 64'h0001_0003_0000_0018, -1};

    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    active = 1'b0; tmode = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1 out_rdy = 1'b1;
    @(negedge clk);
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_pkt_count", 72'(pkt_count), 72'(0));
    chk("rst_rd_en", 72'(mem_rd_en), 72'(0));
    chk("rst_out_wr", 72'(out_wr), 72'(0));
    @(posedge clk); #1 reset = 1'b0;

    foreach (vecs[i])
      run_pkt(vecs[i].base, int'(vecs[i].len), vecs[i].dst, vecs[i].mode, vecs[i].hdr, vecs[i].xs_rel);

    // zero-length start is ignored
    tmode = 1'b0; active = 1'b0;
    step(1'b1, 1'b1, 9'h040, 10'd0, 16'h0007);
    repeat (10) step(1'b1, 1'b0, 9'h000, 10'd0, 16'h0000);
    chk("len0_busy", 72'(busy), 72'(0));
    chk("len0_done_count", 72'(done_cnt), 72'(exp_pkts));
    chk("len0_pkt_count", 72'(pkt_count), 72'(exp_pkts));

    // randomized packets
    for (int n = 0; n < 16; n++) begin
      logic [8:0]  b;
      logic [15:0] d;
      int          l, m;
      b = 9'($urandom_range(0, 511));
      d = 16'($urandom);
      l = $urandom_range(1, 24);
      m = $urandom_range(0, 2);
      run_pkt(b, l, d, m, model_hdr(d, l), -1);
    end

    // reset during payload word 2 of a len=6 packet
    setup(9'h080, 6, model_hdr(16'h0066, 6), 1'b1);
    step(1'b1, 1'b1, 9'h080, 10'd6, 16'h0066);
    for (int k = 1; k < 5; k++) step(1'b1, 1'b0, 9'h000, 10'd0, 16'h0000);
    chk("xfers_before_reset", 72'(xfer_idx), 72'(3));
    @(posedge clk); #1;
    cyc++;
    reset = 1'b1;
    #1;
    chk("midrst_out_wr", 72'(out_wr), 72'(0));
    chk("midrst_busy", 72'(busy), 72'(0));
    chk("midrst_pkt_count", 72'(pkt_count), 72'(0));
    chk("midrst_rd_en", 72'(mem_rd_en), 72'(0));
    exp_q.delete(); addr_q.delete();
    exp_pkts = 0; done_cnt = 0; active = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    run_pkt(9'h1F0, 20, 16'h0042, 0, model_hdr(16'h0042, 20), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
